// File: rtl/mips_ex_bru_pkg.sv
// mips_ex_bru_pkg: shared address width and branch-resolution state encoding
package mips_ex_bru_pkg;
  localparam int MIPS_ADDR_WIDTH = 32;
  typedef enum logic {BRU_IDLE = 1'b0, BRU_REDIR = 1'b1} bru_state_e;
endpackage

// File: rtl/mips_sat_cnt.sv
// mips_sat_cnt: saturating up-counter with synchronous clear taking priority
module mips_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  // count up, stick at all-ones, clear wins over increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mips_ex_bru.sv
// mips_ex_bru: EX-stage branch resolution, redirect/flush on mispredict, perf counters
module mips_ex_bru
  import mips_ex_bru_pkg::*;
#(
  parameter int ADDR_W = MIPS_ADDR_WIDTH,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_jmpimm,
  input  logic              ex_jr,
  input  logic              ex_bxx,
  input  logic              ex_cond_true,
  input  logic              ex_prdt_taken,
  input  logic [ADDR_W-1:0] ex_prdt_pc,
  input  logic [ADDR_W-1:0] ex_pc_incr,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic [ADDR_W-1:0] ex_jr_target,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_pc,
  input  logic              redir_ready,
  output logic              flush,
  output logic              ex_stall,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_branch,
  output logic [CNT_W-1:0]  cnt_mispred
);
  bru_state_e        state, state_nxt;
  logic              resolve, act_taken, mispred, fix;
  logic [ADDR_W-1:0] act_tgt, fix_pc;
  assign resolve   = ex_valid & (ex_jmpimm | ex_jr | ex_bxx) & (state == BRU_IDLE);
  assign act_taken = ex_jr | ex_jmpimm | (ex_bxx & ex_cond_true);
  assign act_tgt   = ex_jr ? ex_jr_target : ex_br_target;
  assign mispred   = (act_taken != ex_prdt_taken) | (act_taken & (ex_prdt_pc != act_tgt));
  assign fix_pc    = act_taken ? act_tgt : ex_pc_incr;
  assign fix       = resolve & mispred;
  assign redir_valid = state == BRU_REDIR;
  assign ex_stall    = state == BRU_REDIR;
  // enter REDIR on a mispredict, leave once IF takes the redirect
  always_comb begin
    state_nxt = state;
    state_nxt = (state == BRU_IDLE) ? (fix ? BRU_REDIR : BRU_IDLE)
                                    : (redir_ready ? BRU_IDLE : BRU_REDIR);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BRU_IDLE;
    else state <= state_nxt;
  // flush pulses on REDIR entry; redirect PC captured then and held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flush    <= 1'b0;
      redir_pc <= '0;
    end else begin
      flush <= fix;
      if (fix) redir_pc <= fix_pc;
    end
  mips_sat_cnt #(.W(CNT_W)) u_cnt_branch (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(resolve), .cnt(cnt_branch)
  );
  mips_sat_cnt #(.W(CNT_W)) u_cnt_mispred (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(fix), .cnt(cnt_mispred)
  );
endmodule

// File: tb/tb_mips_ex_bru.sv
// tb_mips_ex_bru: directed and randomized checks of mips_ex_bru against a behavioural model
module tb_mips_ex_bru;
  localparam int AW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 0, ex_jmpimm = 0, ex_jr = 0, ex_bxx = 0, ex_cond_true = 0, ex_prdt_taken = 0;
  logic [AW-1:0] ex_prdt_pc = 0, ex_pc_incr = 0, ex_br_target = 0, ex_jr_target = 0;
  logic          redir_ready = 0, cnt_clr = 0;
  logic          redir_valid, flush, ex_stall;
  logic [AW-1:0] redir_pc;
  logic [CW-1:0] cnt_branch, cnt_mispred;
  int n_chk = 0, n_pass = 0;
  bit m_redir = 0, m_flush = 0;
  logic [AW-1:0] m_pc = 0;
  int m_br = 0, m_mp = 0;

  mips_ex_bru #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_jmpimm(ex_jmpimm), .ex_jr(ex_jr),
    .ex_bxx(ex_bxx), .ex_cond_true(ex_cond_true), .ex_prdt_taken(ex_prdt_taken),
    .ex_prdt_pc(ex_prdt_pc), .ex_pc_incr(ex_pc_incr), .ex_br_target(ex_br_target),
    .ex_jr_target(ex_jr_target), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready), .flush(flush), .ex_stall(ex_stall), .cnt_clr(cnt_clr),
    .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_redir = 0; m_flush = 0; m_pc = 0; m_br = 0; m_mp = 0;
  endtask

  // one clock: the model applies the stated branch rules to the inputs present at the edge
  task automatic cyc();
    bit res, tk, mp;
    logic [AW-1:0] tg;
    res = ex_valid && (ex_jmpimm || ex_jr || ex_bxx) && !m_redir;
    tk  = ex_jr || ex_jmpimm || (ex_bxx && ex_cond_true);
    tg  = ex_jr ? ex_jr_target : ex_br_target;
    mp  = (tk != ex_prdt_taken) || (tk && ex_prdt_pc != tg);
    @(posedge clk);
    #1;
    if (cnt_clr) begin
      m_br = 0; m_mp = 0;
    end else if (res) begin
      m_br = (m_br == CMAX) ? CMAX : m_br + 1;
      if (mp) m_mp = (m_mp == CMAX) ? CMAX : m_mp + 1;
    end
    m_flush = res && mp;
    if (res && mp) m_pc = tk ? tg : ex_pc_incr;
    m_redir = m_redir ? !redir_ready : (res && mp);
  endtask

  task automatic idle_in();
    ex_valid = 0; ex_jmpimm = 0; ex_jr = 0; ex_bxx = 0; ex_cond_true = 0; ex_prdt_taken = 0;
    ex_prdt_pc = 0; ex_pc_incr = 0; ex_br_target = 0; ex_jr_target = 0; cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle_in();
    redir_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (redir_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", redir_valid); else n_pass++;
    n_chk++; if (flush !== 1'b0) $display("FAIL reset_flush got %b want 0", flush); else n_pass++;
    n_chk++; if (ex_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", ex_stall); else n_pass++;
    n_chk++; if (redir_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", redir_pc); else n_pass++;
    n_chk++; if (cnt_branch !== 4'd0 || cnt_mispred !== 4'd0)
      $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt_branch, cnt_mispred); else n_pass++;
    rst_n = 1;
    model_reset();
    cyc();
  endtask

  task automatic test_correct_bxx();
    ex_valid = 1; ex_bxx = 1; ex_prdt_taken = 1; ex_prdt_pc = 32'hF0; ex_br_target = 32'hF0; ex_cond_true = 1;
    ex_pc_incr = 32'h104;
    cyc();
    idle_in();
    n_chk++; if (redir_valid !== 1'b0 || flush !== 1'b0)
      $display("FAIL ok_bxx_redir got valid=%b flush=%b want 0/0", redir_valid, flush); else n_pass++;
    n_chk++; if (cnt_branch !== 4'd1 || cnt_mispred !== 4'd0)
      $display("FAIL ok_bxx_cnt got %0d/%0d want 1/0", cnt_branch, cnt_mispred); else n_pass++;
  endtask

  task automatic test_mispred_taken();
    redir_ready = 1;
    ex_valid = 1; ex_bxx = 1; ex_prdt_taken = 0; ex_cond_true = 1; ex_br_target = 32'h140; ex_pc_incr = 32'h204;
    cyc();
    idle_in();
    n_chk++; if (redir_valid !== 1'b1 || flush !== 1'b1 || ex_stall !== 1'b1)
      $display("FAIL mp_taken_n1 got valid=%b flush=%b stall=%b want 1/1/1", redir_valid, flush, ex_stall); else n_pass++;
    n_chk++; if (redir_pc !== 32'h140) $display("FAIL mp_taken_pc got %h want 00000140", redir_pc); else n_pass++;
    cyc();
    n_chk++; if (redir_valid !== 1'b0 || flush !== 1'b0 || ex_stall !== 1'b0)
      $display("FAIL mp_taken_n2 got valid=%b flush=%b stall=%b want 0/0/0", redir_valid, flush, ex_stall); else n_pass++;
    n_chk++; if (cnt_branch !== 4'd2 || cnt_mispred !== 4'd1)
      $display("FAIL mp_taken_cnt got %0d/%0d want 2/1", cnt_branch, cnt_mispred); else n_pass++;
  endtask

  task automatic test_mispred_not_taken();
    redir_ready = 1;
    ex_valid = 1; ex_bxx = 1; ex_prdt_taken = 1; ex_prdt_pc = 32'h80; ex_cond_true = 0;
    ex_pc_incr = 32'h104; ex_br_target = 32'h80;
    cyc();
    idle_in();
    n_chk++; if (redir_valid !== 1'b1 || redir_pc !== 32'h104)
      $display("FAIL mp_nt_n1 got valid=%b pc=%h want 1/00000104", redir_valid, redir_pc); else n_pass++;
    cyc();
    n_chk++; if (redir_valid !== 1'b0) $display("FAIL mp_nt_n2 got valid=%b want 0", redir_valid); else n_pass++;
  endtask

  task automatic test_jr_wait();
    redir_ready = 0;
    ex_valid = 1; ex_jr = 1; ex_prdt_taken = 1; ex_prdt_pc = 0; ex_jr_target = 32'h0040_0000;
    cyc();
    n_chk++; if (redir_valid !== 1'b1 || flush !== 1'b1 || ex_stall !== 1'b1 || redir_pc !== 32'h0040_0000)
      $display("FAIL jr_c1 got valid=%b flush=%b stall=%b pc=%h want 1/1/1/00400000",
               redir_valid, flush, ex_stall, redir_pc); else n_pass++;
    idle_in();
    ex_valid = 1; ex_bxx = 1; ex_cond_true = 1; ex_prdt_taken = 0; ex_br_target = 32'h999;
    for (int c = 2; c <= 4; c++) begin
      cyc();
      n_chk++; if (redir_valid !== 1'b1 || flush !== 1'b0 || ex_stall !== 1'b1 || redir_pc !== 32'h0040_0000)
        $display("FAIL jr_c%0d got valid=%b flush=%b stall=%b pc=%h want 1/0/1/00400000",
                 c, redir_valid, flush, ex_stall, redir_pc); else n_pass++;
    end
    redir_ready = 1;
    idle_in();
    cyc();
    n_chk++; if (redir_valid !== 1'b0 || ex_stall !== 1'b0)
      $display("FAIL jr_done got valid=%b stall=%b want 0/0", redir_valid, ex_stall); else n_pass++;
    n_chk++; if (cnt_branch !== 4'd4 || cnt_mispred !== 4'd3)
      $display("FAIL jr_cnt got %0d/%0d want 4/3", cnt_branch, cnt_mispred); else n_pass++;
  endtask

  task automatic test_saturate();
    cnt_clr = 1;
    cyc();
    cnt_clr = 0;
    ex_valid = 1; ex_jmpimm = 1; ex_prdt_taken = 1; ex_prdt_pc = 32'h300; ex_br_target = 32'h300;
    repeat (17) cyc();
    n_chk++; if (cnt_branch !== 4'd15 || cnt_mispred !== 4'd0)
      $display("FAIL sat_cnt got %0d/%0d want 15/0", cnt_branch, cnt_mispred); else n_pass++;
    n_chk++; if (redir_valid !== 1'b0) $display("FAIL sat_redir got %b want 0", redir_valid); else n_pass++;
    cnt_clr = 1;
    cyc();
    idle_in();
    n_chk++; if (cnt_branch !== 4'd0 || cnt_mispred !== 4'd0)
      $display("FAIL clr_prio got %0d/%0d want 0/0", cnt_branch, cnt_mispred); else n_pass++;
  endtask

  task automatic test_async_reset();
    redir_ready = 0;
    ex_valid = 1; ex_bxx = 1; ex_cond_true = 1; ex_prdt_taken = 0; ex_br_target = 32'h1234;
    cyc();
    idle_in();
    cyc();
    n_chk++; if (redir_valid !== 1'b1 || cnt_branch !== 4'd1 || redir_pc !== 32'h1234)
      $display("FAIL ar_pre got valid=%b cnt=%0d pc=%h want 1/1/00001234", redir_valid, cnt_branch, redir_pc); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_chk++; if (redir_valid !== 1'b0 || flush !== 1'b0 || ex_stall !== 1'b0 || redir_pc !== 32'h0)
      $display("FAIL ar_out got valid=%b flush=%b stall=%b pc=%h want 0/0/0/0",
               redir_valid, flush, ex_stall, redir_pc); else n_pass++;
    n_chk++; if (cnt_branch !== 4'd0 || cnt_mispred !== 4'd0)
      $display("FAIL ar_cnt got %0d/%0d want 0/0", cnt_branch, cnt_mispred); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    redir_ready = 1;
    cyc();
    n_chk++; if (redir_valid !== 1'b0 || ex_stall !== 1'b0)
      $display("FAIL ar_idle got valid=%b stall=%b want 0/0", redir_valid, ex_stall); else n_pass++;
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [4];
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h0040_0000; pool[3] = $urandom;
    for (int i = 0; i < 400; i++) begin
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_jmpimm     = ($urandom_range(0, 3) == 0);
      ex_jr         = ($urandom_range(0, 3) == 0);
      ex_bxx        = ($urandom_range(0, 1) == 0);
      ex_cond_true  = $urandom_range(0, 1);
      ex_prdt_taken = $urandom_range(0, 1);
      ex_prdt_pc    = pool[$urandom_range(0, 3)];
      ex_br_target  = pool[$urandom_range(0, 3)];
      ex_jr_target  = pool[$urandom_range(0, 3)];
      ex_pc_incr    = $urandom;
      redir_ready   = $urandom_range(0, 1);
      cnt_clr       = ($urandom_range(0, 40) == 0);
      cyc();
      n_chk++;
      if (redir_valid !== m_redir || ex_stall !== m_redir || flush !== m_flush || redir_pc !== m_pc ||
          cnt_branch !== m_br[CW-1:0] || cnt_mispred !== m_mp[CW-1:0])
        $display("FAIL rand_%0d got v=%b s=%b f=%b pc=%h br=%0d mp=%0d want v=%b s=%b f=%b pc=%h br=%0d mp=%0d",
                 i, redir_valid, ex_stall, flush, redir_pc, cnt_branch, cnt_mispred,
                 m_redir, m_redir, m_flush, m_pc, m_br, m_mp);
      else n_pass++;
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_correct_bxx();
    test_mispred_taken();
    test_mispred_not_taken();
    test_jr_wait();
    test_saturate();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mips_ex_bru.md
Name: mips_ex_bru

Overview:
Branch resolution unit in the EX stage; the closing end of the IF-stage static prediction path. It compares the prediction carried down the pipe (taken flag and target) against the real outcome computed in EX. On a mismatch it issues a registered redirect to IF, pulses a flush of the younger IF/ID instructions, and holds EX until IF accepts the redirect. It also keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
ADDR_W, 32 (`MIPS_ADDR_WIDTH), address width
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX holds a valid instruction
ex_jmpimm  in  1  j/jal in EX
ex_jr  in  1  jr/jalr in EX
ex_bxx  in  1  conditional branch in EX
ex_cond_true  in  1  branch condition evaluated true
ex_prdt_taken  in  1  prediction taken flag from IF, piped to EX
ex_prdt_pc  in  ADDR_W  predicted target from IF, piped to EX
ex_pc_incr  in  ADDR_W  PC+4 of the branch
ex_br_target  in  ADDR_W  EX-computed target for bxx/j/jal
ex_jr_target  in  ADDR_W  rs value for jr/jalr
redir_valid  out  1  redirect request to IF
redir_pc  out  ADDR_W  correct next PC
redir_ready  in  1  IF accepts redirect
flush  out  1  kill younger IF/ID instructions; one-cycle pulse
ex_stall  out  1  hold EX and earlier stages
cnt_clr  in  1  synchronous clear of both counters
cnt_branch  out  CNT_W  resolved control-transfer count
cnt_mispred  out  CNT_W  mispredict count

Behaviour:
- Reset values: state IDLE; redir_valid=0, redir_pc=0, flush=0, ex_stall=0, both counters 0. Reset is asynchronous at any time, including during REDIR.
- Resolve condition: ex_valid & (ex_jmpimm|ex_jr|ex_bxx) & state==IDLE.
- Flag priority when several are set (illegal input): jr > jmpimm > bxx.
- act_taken = ex_jr | ex_jmpimm | (ex_bxx & ex_cond_true).
- act_tgt = ex_jr ? ex_jr_target : ex_br_target.
- mispred = (act_taken != ex_prdt_taken) | (act_taken & (ex_prdt_pc != act_tgt)).
- Next PC: fix_pc = act_taken ? act_tgt : ex_pc_incr. All compares are full ADDR_W equality.
- FSM IDLE:
  - resolve & mispred -> REDIR next cycle.
  - redir_pc <= fix_pc.
  - flush=1 for the first REDIR cycle only.
- FSM REDIR:
  - redir_valid=1, ex_stall=1.
  - redir_pc is held stable.
  - redir_valid & redir_ready -> IDLE next cycle, redir_valid drops.
  - ready=1 on entry gives a single-cycle REDIR.
- Latency: mispredict seen in cycle N -> redir_valid/flush in N+1.
- ex_valid during REDIR: ignored. EX is stalled, no resolve, no counting.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- Counters:
  - cnt_branch +1 on every resolve.
  - cnt_mispred +1 on resolve & mispred.
  - Both saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle (result 0).

Decomposition:
- Shared defines header (mips_defines.vh): `MIPS_ADDR_WIDTH and state encodings BRU_IDLE=1'b0, BRU_REDIR=1'b1.
- One natural sub-module: mips_sat_cnt (parameterised saturating counter with sync clear), instantiated twice.

Test Plan:
1. bxx, prdt_taken=1, prdt_pc=br_target=0x0000_00F0, cond_true=1 -> no redir_valid/flush; cnt_branch=1, cnt_mispred=0.
2. bxx, prdt_taken=0, cond_true=1, br_target=0x0000_0140, redir_ready=1 -> N+1: redir_valid=1, redir_pc=0x140, flush=1, ex_stall=1; N+2: all 0; cnt_mispred=1.
3. bxx, prdt_taken=1, prdt_pc=0x80, cond_true=0, pc_incr=0x104 -> redir_pc=0x104, one-cycle redirect.
4. jr, prdt_taken=1, prdt_pc=0, jr_target=0x0040_0000, redir_ready low for 3 cycles then high:
   - redir_valid high 4 cycles, redir_pc constant, flush only in cycle 1, ex_stall high 4 cycles.
   - A second ex_valid branch during the wait is not counted.
5. CNT_W=4, 17 correctly predicted jmpimm branches -> cnt_branch=15 (saturated). Then cnt_clr together with a resolve -> 0.
6. rst_n low in the second REDIR cycle -> redir_valid, flush, ex_stall, redir_pc and counters 0 immediately, without waiting for clk. IDLE after release.
